// File: rtl/flag_pkg.sv
// Shared types for the flag/condition unit: flag bundle, condition codes, query FSM states.
package flag_pkg;

  localparam int PEND_W_DEF = 3;

  typedef struct packed {
    logic c;
    logic z;
    logic o;
    logic s;
  } flags_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fcu_state_e;

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Combinational condition-code evaluator over the architectural flags.
module cond_eval
  import flag_pkg::*;
(
  input  flags_t flags,
  input  cond_e  code,
  output logic   taken
);

  // Table lookup of condition against {c,z,o,s}
  always_comb begin
    taken = 1'b0;
    case (code)
      COND_EQ: taken = flags.z;
      COND_NE: taken = ~flags.z;
      COND_CS: taken = flags.c;
      COND_CC: taken = ~flags.c;
      COND_MI: taken = flags.s;
      COND_PL: taken = ~flags.s;
      COND_VS: taken = flags.o;
      COND_VC: taken = ~flags.o;
      COND_HI: taken = flags.c & ~flags.z;
      COND_LS: taken = ~flags.c | flags.z;
      COND_GE: taken = (flags.s == flags.o);
      COND_LT: taken = (flags.s != flags.o);
      COND_GT: taken = ~flags.z & (flags.s == flags.o);
      COND_LE: taken = flags.z | (flags.s != flags.o);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural flag register, in-flight flag-writer tracking and stalled condition queries.
module flag_cond_unit
  import flag_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_flags,
  input  logic              flag_wr_valid,
  input  logic [3:0]        flag_wr_mask,
  input  logic              c_flag,
  input  logic              z_flag,
  input  logic              o_flag,
  input  logic              s_flag,
  input  logic              cond_valid,
  input  logic [3:0]        cond_code,
  output logic              cond_ready,
  output logic              res_valid,
  output logic              res_taken,
  input  logic              res_ready,
  output logic [3:0]        flags_q,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              pend_full,
  output logic [1:0]        err
);

  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

  flags_t            flags;
  logic [PEND_W-1:0] pend;
  fcu_state_e        state;
  cond_e             code_q;
  logic              eval_taken;

  assign flags_q    = flags;
  assign pend_cnt   = pend;
  assign pend_full  = (pend == PEND_MAX);
  assign cond_ready = rst_n & (state == ST_IDLE);

  cond_eval u_cond_eval (
    .flags (flags),
    .code  (code_q),
    .taken (eval_taken)
  );

  // Per-bit masked flag write on retire
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags <= 4'h0;
    end else if (flag_wr_valid) begin
      if (flag_wr_mask[3]) flags.c <= c_flag;
      if (flag_wr_mask[2]) flags.z <= z_flag;
      if (flag_wr_mask[1]) flags.o <= o_flag;
      if (flag_wr_mask[0]) flags.s <= s_flag;
    end
  end

  // In-flight counter; overflow/underflow attempts saturate and set sticky error bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= PEND_ZERO;
      err  <= 2'b00;
    end else begin
      case ({issue_flags, flag_wr_valid})
        2'b10: begin
          if (pend == PEND_MAX) err[1] <= 1'b1;
          else                  pend   <= pend + PEND_ONE;
        end
        2'b01: begin
          if (pend == PEND_ZERO) err[0] <= 1'b1;
          else                   pend   <= pend - PEND_ONE;
        end
        default: pend <= pend;
      endcase
    end
  end

  // Query FSM: evaluation waits a cycle past any retire so it sees the updated flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      code_q    <= COND_EQ;
      res_valid <= 1'b0;
      res_taken <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cond_valid && cond_ready) begin
            code_q <= cond_e'(cond_code);
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if ((pend == PEND_ZERO) && !flag_wr_valid) begin
            res_taken <= eval_taken;
            res_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed self-checking bench for flag_cond_unit.
module tb_flag_cond_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_flags, flag_wr_valid;
  logic [3:0] flag_wr_mask;
  logic       c_flag, z_flag, o_flag, s_flag;
  logic       cond_valid;
  logic [3:0] cond_code;
  logic       cond_ready, res_valid, res_taken, res_ready;
  logic [3:0] flags_q;
  logic [2:0] pend_cnt;
  logic       pend_full;
  logic [1:0] err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  flag_cond_unit #(.PEND_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .issue_flags(issue_flags), .flag_wr_valid(flag_wr_valid),
    .flag_wr_mask(flag_wr_mask), .c_flag(c_flag), .z_flag(z_flag), .o_flag(o_flag),
    .s_flag(s_flag), .cond_valid(cond_valid), .cond_code(cond_code), .cond_ready(cond_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready), .flags_q(flags_q),
    .pend_cnt(pend_cnt), .pend_full(pend_full), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_flags = 1'b0; flag_wr_valid = 1'b0; flag_wr_mask = 4'h0;
    c_flag = 1'b0; z_flag = 1'b0; o_flag = 1'b0; s_flag = 1'b0;
    cond_valid = 1'b0; cond_code = 4'h0; res_ready = 1'b0;
  endtask

  task automatic drive_flags(input logic [3:0] f, input logic [3:0] mask);
    flag_wr_valid = 1'b1; flag_wr_mask = mask;
    c_flag = f[3]; z_flag = f[2]; o_flag = f[1]; s_flag = f[0];
  endtask

  function automatic logic model_taken(input logic [3:0] f, input logic [3:0] code);
    logic c, z, o, s;
    c = f[3]; z = f[2]; o = f[1]; s = f[0];
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return s;
      4'd5:  return !s;
      4'd6:  return o;
      4'd7:  return !o;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return s == o;
      4'd11: return s != o;
      4'd12: return !z && (s == o);
      4'd13: return z || (s != o);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++;
    if ({flags_q, pend_cnt, err, res_valid, res_taken, cond_ready} !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_state: got flags=%h pend=%0d err=%b rv=%b rt=%b rdy=%b, want all 0",
               flags_q, pend_cnt, err, res_valid, res_taken, cond_ready);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (cond_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: got %b want 1", cond_ready);
    end
  endtask

  task automatic test_basic_query();
    issue_flags = 1'b1; tick();
    issue_flags = 1'b0; drive_flags(4'b1000, 4'hF); tick();
    clear_inputs();
    n_checks++;
    if (flags_q !== 4'b1000 || pend_cnt !== 3'd0 || err !== 2'b00) begin
      n_errors++;
      $display("FAIL t1_retire: got flags=%b pend=%0d err=%b want 1000/0/00", flags_q, pend_cnt, err);
    end
    cond_valid = 1'b1; cond_code = 4'd2; tick();
    cond_valid = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || cond_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL t1_n1: got rv=%b rdy=%b want 0/0", res_valid, cond_ready);
    end
    tick();
    n_checks++;
    if (res_valid !== 1'b1 || res_taken !== 1'b1) begin
      n_errors++;
      $display("FAIL t1_cs_result: got rv=%b rt=%b want 1/1", res_valid, res_taken);
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || cond_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL t1_handshake: got rv=%b rdy=%b want 0/1", res_valid, cond_ready);
    end
  endtask

  task automatic test_stall();
    issue_flags = 1'b1; tick(); tick();
    issue_flags = 1'b0;
    cond_valid = 1'b1; cond_code = 4'd0; tick();
    cond_valid = 1'b0;
    tick(); tick();
    n_checks++;
    if (res_valid !== 1'b0 || cond_ready !== 1'b0 || pend_cnt !== 3'd2) begin
      n_errors++;
      $display("FAIL t2_stall: got rv=%b rdy=%b pend=%0d want 0/0/2", res_valid, cond_ready, pend_cnt);
    end
    drive_flags(4'b0100, 4'hF); tick();
    drive_flags(4'b0000, 4'hF); tick();
    clear_inputs();
    n_checks++;
    if (res_valid !== 1'b0 || pend_cnt !== 3'd0) begin
      n_errors++;
      $display("FAIL t2_deferred: got rv=%b pend=%0d want 0/0", res_valid, pend_cnt);
    end
    tick();
    n_checks++;
    if (res_valid !== 1'b1 || res_taken !== 1'b0) begin
      n_errors++;
      $display("FAIL t2_eq_result: got rv=%b rt=%b want 1/0", res_valid, res_taken);
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_back_to_back_issue_retire();
    issue_flags = 1'b1; tick();
    drive_flags(4'b1111, 4'b0100); tick();
    clear_inputs();
    n_checks++;
    if (pend_cnt !== 3'd1 || flags_q !== 4'b0100) begin
      n_errors++;
      $display("FAIL t3_same_cycle: got pend=%0d flags=%b want 1/0100", pend_cnt, flags_q);
    end
    drive_flags(4'b0000, 4'h0); tick();
    clear_inputs();
    n_checks++;
    if (pend_cnt !== 3'd0 || flags_q !== 4'b0100 || err !== 2'b00) begin
      n_errors++;
      $display("FAIL t3_mask0: got pend=%0d flags=%b err=%b want 0/0100/00", pend_cnt, flags_q, err);
    end
  endtask

  task automatic test_saturation();
    issue_flags = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    issue_flags = 1'b0;
    n_checks++;
    if (pend_cnt !== 3'd7 || pend_full !== 1'b1 || err !== 2'b00) begin
      n_errors++;
      $display("FAIL t4_full: got pend=%0d full=%b err=%b want 7/1/00", pend_cnt, pend_full, err);
    end
    issue_flags = 1'b1; tick(); issue_flags = 1'b0;
    n_checks++;
    if (pend_cnt !== 3'd7 || err !== 2'b10) begin
      n_errors++;
      $display("FAIL t4_overflow: got pend=%0d err=%b want 7/10", pend_cnt, err);
    end
    for (int i = 0; i < 7; i++) begin
      drive_flags(4'b0000, 4'h0); tick();
    end
    clear_inputs();
    n_checks++;
    if (pend_cnt !== 3'd0 || pend_full !== 1'b0 || err !== 2'b10) begin
      n_errors++;
      $display("FAIL t4_drain: got pend=%0d full=%b err=%b want 0/0/10", pend_cnt, pend_full, err);
    end
    drive_flags(4'b1010, 4'hF); tick();
    clear_inputs();
    n_checks++;
    if (pend_cnt !== 3'd0 || err !== 2'b11 || flags_q !== 4'b1010) begin
      n_errors++;
      $display("FAIL t4_underflow: got pend=%0d err=%b flags=%b want 0/11/1010", pend_cnt, err, flags_q);
    end
  endtask

  task automatic test_sweep();
    logic exp;
    for (int f = 0; f < 16; f++) begin
      issue_flags = 1'b1; tick();
      issue_flags = 1'b0; drive_flags(f[3:0], 4'hF); tick();
      clear_inputs();
      for (int code = 0; code < 16; code++) begin
        cond_valid = 1'b1; cond_code = code[3:0]; tick();
        cond_valid = 1'b0; tick();
        exp = model_taken(f[3:0], code[3:0]);
        n_checks++;
        if (res_valid !== 1'b1 || res_taken !== exp) begin
          n_errors++;
          $display("FAIL sweep flags=%b code=%0d: got rv=%b rt=%b want 1/%b",
                   f[3:0], code, res_valid, res_taken, exp);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
      end
    end
    // flags now 1111: LT is false, GE true
    cond_valid = 1'b1; cond_code = 4'd10; tick();
    cond_valid = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (res_valid !== 1'b1 || res_taken !== 1'b1 || cond_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL t5_hold cycle %0d: got rv=%b rt=%b rdy=%b want 1/1/0",
                 i, res_valid, res_taken, cond_ready);
      end
      tick();
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL t5_release: got rv=%b want 0", res_valid);
    end
  endtask

  task automatic test_reset_in_wait();
    issue_flags = 1'b1; tick(); issue_flags = 1'b0;
    cond_valid = 1'b1; cond_code = 4'd14; tick();
    cond_valid = 1'b0; tick();
    n_checks++;
    if (res_valid !== 1'b0 || cond_ready !== 1'b0 || pend_cnt !== 3'd1) begin
      n_errors++;
      $display("FAIL t6_wait: got rv=%b rdy=%b pend=%0d want 0/0/1", res_valid, cond_ready, pend_cnt);
    end
    rst_n = 1'b0; tick();
    n_checks++;
    if (res_valid !== 1'b0 || pend_cnt !== 3'd0 || err !== 2'b00 || cond_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL t6_reset: got rv=%b pend=%0d err=%b rdy=%b want 0/0/00/0",
               res_valid, pend_cnt, err, cond_ready);
    end
    rst_n = 1'b1; #1;
    n_checks++;
    if (cond_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL t6_ready: got %b want 1", cond_ready);
    end
    tick(); tick(); tick();
    n_checks++;
    if (res_valid !== 1'b0 || cond_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL t6_abandoned: got rv=%b rdy=%b want 0/1", res_valid, cond_ready);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_basic_query();
    test_stall();
    test_back_to_back_issue_retire();
    test_saturation();
    test_sweep();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
